// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//
// Owns the program counter. In FETCH it offers pc to instruction memory and
// steps it by PC_STEP on every accepted fetch. A resolved branch/jump
// (br_req) interrupts this with a three-state redirect:
//   FETCH --br_req--> CALC (target = base + immediate, registered)
//         --> REDIRECT (pc <= taken ? target : br_pc + PC_STEP) --> FETCH
// so a br_req sampled at cycle N shows the new pc with fetch_valid=1 at N+3.
//
// Optional feature (compile-time macro PC_MISALIGN_TRAP_EN):
//   when defined, a taken target with bit 1 set redirects to TRAP_VECTOR and
//   pulses misalign for one cycle. When undefined the target is used as-is,
//   misalign is constant 0 and TRAP_VECTOR has no effect.
//
// Fetch handshake: pc is a request while fetch_valid=1. A fetch is consumed
// (pc advances) only on a cycle with fetch_valid && imem_ready && !stall;
// otherwise pc is held stable and fetch_valid stays high.
//
// Ports
//   clock        in   1   rising-edge clock
//   reset        in   1   synchronous, active-high; overrides everything
//   stall        in   1   hold pc in FETCH (ignored in CALC/REDIRECT)
//   imem_ready   in   1   instruction memory accepts pc this cycle
//   fetch_valid  out  1   pc is a valid fetch address
//   pc           out  32  current fetch address
//   br_req       in   1   branch/jump resolved (sampled only in FETCH)
//   br_taken     in   1   1 = take target, 0 = fall through
//   br_is_jalr   in   1   base is rs1_value and target bit 0 is cleared
//   br_pc        in   32  pc of the branch instruction
//   rs1_value    in   32  register base for JALR
//   immediate    in   32  sign-extended offset
//   busy         out  1   redirect in progress; br_req ignored
//   misalign     out  1   one-cycle pulse on a trapped misaligned target
//   state_dbg    out  2   current FSM state (0 IDLE,1 FETCH,2 CALC,3 REDIRECT)
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module pc_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] PC_STEP     = 32'd4,
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        imem_ready,
    output logic        fetch_valid,
    output logic [31:0] pc,
    input  logic        br_req,
    input  logic        br_taken,
    input  logic        br_is_jalr,
    input  logic [31:0] br_pc,
    input  logic [31:0] rs1_value,
    input  logic [31:0] immediate,
    output logic        busy,
    output logic        misalign,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FETCH    = 2'd1,
        ST_CALC     = 2'd2,
        ST_REDIRECT = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        fetch_valid_q, fetch_valid_d;
    logic        busy_q, busy_d;
    logic        misalign_q, misalign_d;

    // Branch context captured on br_req.
    logic        taken_q, taken_d;
    logic        jalr_q, jalr_d;
    logic [31:0] br_pc_q, br_pc_d;
    logic [31:0] base_q, base_d;
    logic [31:0] imm_q, imm_d;
    logic [31:0] target_q, target_d;

    logic [31:0] sum;

`ifndef PC_MISALIGN_TRAP_EN
    logic unused_trap_vector;
    assign unused_trap_vector = ^TRAP_VECTOR;
`endif

    // ---------------- state register (and all other flops) ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            fetch_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            misalign_q    <= 1'b0;
            taken_q       <= 1'b0;
            jalr_q        <= 1'b0;
            br_pc_q       <= 32'd0;
            base_q        <= 32'd0;
            imm_q         <= 32'd0;
            target_q      <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_valid_q <= fetch_valid_d;
            busy_q        <= busy_d;
            misalign_q    <= misalign_d;
            taken_q       <= taken_d;
            jalr_q        <= jalr_d;
            br_pc_q       <= br_pc_d;
            base_q        <= base_d;
            imm_q         <= imm_d;
            target_q      <= target_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     state_d = ST_FETCH;
            ST_FETCH:    if (br_req) state_d = ST_CALC;
            ST_CALC:     state_d = ST_REDIRECT;
            ST_REDIRECT: state_d = ST_FETCH;
            default:     state_d = ST_IDLE;
        endcase
    end

    // ---------------- datapath / registered-output logic ----------------
    // Outputs are computed from state_d so they line up with the state
    // they describe once registered.
    always_comb begin
        pc_d       = pc_q;
        taken_d    = taken_q;
        jalr_d     = jalr_q;
        br_pc_d    = br_pc_q;
        base_d     = base_q;
        imm_d      = imm_q;
        target_d   = target_q;
        misalign_d = 1'b0;
        sum        = base_q + imm_q;

        case (state_q)
            ST_FETCH: begin
                // A branch wins over the sequential advance in the same
                // cycle, and stall does not hold it off.
                if (br_req) begin
                    taken_d = br_taken;
                    jalr_d  = br_is_jalr;
                    br_pc_d = br_pc;
                    base_d  = br_is_jalr ? rs1_value : br_pc;
                    imm_d   = immediate;
                end else if (fetch_valid_q && imem_ready && !stall) begin
                    pc_d = pc_q + PC_STEP;
                end
            end
            ST_CALC: begin
                target_d = jalr_q ? {sum[31:1], 1'b0} : sum;
            end
            ST_REDIRECT: begin
                if (taken_q) begin
`ifdef PC_MISALIGN_TRAP_EN
                    if (target_q[1]) begin
                        pc_d       = TRAP_VECTOR;
                        misalign_d = 1'b1;
                    end else begin
                        pc_d = target_q;
                    end
`else
                    pc_d = target_q;
`endif
                end else begin
                    // Fall-through never traps, whatever its alignment.
                    pc_d = br_pc_q + PC_STEP;
                end
            end
            default: ;
        endcase

        fetch_valid_d = (state_d == ST_FETCH);
        busy_d        = (state_d == ST_CALC) || (state_d == ST_REDIRECT);
    end

    assign pc          = pc_q;
    assign fetch_valid = fetch_valid_q;
    assign busy        = busy_q;
    assign misalign    = misalign_q;
    assign state_dbg   = state_q;

endmodule
